// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, asynchronous-read word memory between the I-fetch and D sides.
// Each access holds the memory for LATENCY cycles, then pulses a one-cycle response to its owner.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_valid,
  output logic          i_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_resp_valid,
  output logic [31:0]   i_resp_data,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_req_addr,
  input  logic          d_req_write,
  input  logic [31:0]   d_req_wdata,
  output logic          d_resp_valid,
  output logic [31:0]   d_resp_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  // Owner encoding for both owner registers: 1 = D side, 0 = I side.
  logic          lastOwner_q, lastOwner_d;
  logic          owner_q, owner_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grantI, grantD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b0;
      owner_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lastOwner_d  = lastOwner_q;
    owner_d      = owner_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    grantI       = 1'b0;
    grantD       = 1'b0;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    i_resp_data  = '0;
    d_resp_valid = 1'b0;
    d_resp_data  = '0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // On a tie the side that did not own the previous access wins.
        grantD      = d_req_valid & (~i_req_valid | ~lastOwner_q);
        grantI      = i_req_valid & ~grantD;
        i_req_ready = grantI;
        d_req_ready = grantD;
        if (grantI || grantD) begin
          owner_d     = grantD;
          lastOwner_d = grantD;
          addr_d      = grantD ? d_req_addr : i_req_addr;
          write_d     = grantD & d_req_write;
          wdata_d     = grantD ? d_req_wdata : '0;
          cnt_d       = CW'(LATENCY - 1);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) begin
          mem_we  = write_q;
          data_d  = write_q ? wdata_q : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        i_resp_valid = ~owner_q;
        i_resp_data  = owner_q ? '0 : data_q;
        d_resp_valid = owner_q;
        d_resp_data  = owner_q ? data_q : '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are held quiet while reset is asserted so an interrupted access leaks nothing.
    if (reset) begin
      i_req_ready  = 1'b0;
      d_req_ready  = 1'b0;
      i_resp_valid = 1'b0;
      i_resp_data  = '0;
      d_resp_valid = 1'b0;
      d_resp_data  = '0;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      busy         = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a LATENCY=4 instance with a word memory model,
// plus a LATENCY=1 instance reading a combinational address pattern.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iReqValid, iReqReady, iRespValid;
  logic [31:0] iReqAddr, iRespData;
  logic        dReqValid, dReqReady, dReqWrite, dRespValid;
  logic [31:0] dReqAddr, dReqWdata, dRespData;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memWe, busy;

  logic        u1IValid, u1IReady, u1IRespValid;
  logic [31:0] u1IAddr, u1IRespData;
  logic        u1DValid, u1DReady, u1DWrite, u1DRespValid;
  logic [31:0] u1DAddr, u1DWdata, u1DRespData;
  logic [31:0] u1MemAddr, u1MemWdata, u1MemRdata;
  logic        u1MemWe, u1Busy;

  mem_port_arbiter #(.LATENCY(LAT), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(iReqValid), .i_req_ready(iReqReady), .i_req_addr(iReqAddr),
    .i_resp_valid(iRespValid), .i_resp_data(iRespData),
    .d_req_valid(dReqValid), .d_req_ready(dReqReady), .d_req_addr(dReqAddr),
    .d_req_write(dReqWrite), .d_req_wdata(dReqWdata),
    .d_resp_valid(dRespValid), .d_resp_data(dRespData),
    .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .busy(busy)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(32)) dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(u1IValid), .i_req_ready(u1IReady), .i_req_addr(u1IAddr),
    .i_resp_valid(u1IRespValid), .i_resp_data(u1IRespData),
    .d_req_valid(u1DValid), .d_req_ready(u1DReady), .d_req_addr(u1DAddr),
    .d_req_write(u1DWrite), .d_req_wdata(u1DWdata),
    .d_resp_valid(u1DRespValid), .d_resp_data(u1DRespData),
    .mem_addr(u1MemAddr), .mem_we(u1MemWe), .mem_wdata(u1MemWdata), .mem_rdata(u1MemRdata),
    .busy(u1Busy)
  );

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t        iQ[$];
  exp_t        dQ[$];
  exp_t        u1Q[$];
  int          total = 0;
  int          bad = 0;
  int          cycleCount = 0;
  int          weCount = 0;
  logic [31:0] weAddr = '0;
  logic [31:0] weData = '0;
  logic [31:0] mem [0:255];

  // Memory reloads its known pattern on reset: word k holds 0xA0000000+k, except word 4.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    if (reset) begin
      for (int k = 0; k < 256; k++)
        mem[k] <= (k == 4) ? 32'hDEADBEEF : (32'hA000_0000 + 32'(k));
    end else if (memWe) begin
      mem[memAddr[9:2]] <= memWdata;
      weCount           <= weCount + 1;
      weAddr            <= memAddr;
      weData            <= memWdata;
    end
  end

  assign memRdata   = mem[memAddr[9:2]];
  assign u1MemRdata = 32'hC0DE_0000 | {22'd0, u1MemAddr[9:0]};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Holds each requested side valid until it is accepted, queuing its expected response.
  task automatic applyStimulus(
    input logic iv, input logic [31:0] ia, input logic [31:0] iExp,
    input logic dv, input logic [31:0] da, input logic dw, input logic [31:0] dwd,
    input logic [31:0] dExp, input logic expectResp,
    output int sCyc, output int iAcc, output int dAcc);
    logic iDone, dDone;
    int   waitCycles;
    iDone = !iv;
    dDone = !dv;
    iAcc = -1;
    dAcc = -1;
    waitCycles = 0;
    @(negedge clk);
    sCyc      = cycleCount;
    iReqValid = iv;
    iReqAddr  = ia;
    dReqValid = dv;
    dReqAddr  = da;
    dReqWrite = dw;
    dReqWdata = dwd;
    while (!(iDone && dDone) && waitCycles < 40) begin
      #1;
      if (!iDone && iReqReady) begin
        iDone = 1'b1;
        iAcc  = cycleCount;
        if (expectResp) iQ.push_back('{iExp, cycleCount + LAT + 1});
      end
      if (!dDone && dReqReady) begin
        dDone = 1'b1;
        dAcc  = cycleCount;
        if (expectResp) dQ.push_back('{dExp, cycleCount + LAT + 1});
      end
      if (!(iDone && dDone)) begin
        @(negedge clk);
        waitCycles++;
        if (iDone) begin iReqValid = 1'b0; iReqAddr = 32'hFFFF_FFF0; end
        if (dDone) begin dReqValid = 1'b0; dReqAddr = 32'hFFFF_FFF0; dReqWdata = '0; end
      end
    end
    checkOutput("accept_within_bound", {31'd0, iDone & dDone}, 32'd1);
    @(posedge clk);
    #1;
    iReqValid = 1'b0;
    dReqValid = 1'b0;
    iReqAddr  = 32'hFFFF_FFF0;
    dReqAddr  = 32'hFFFF_FFF0;
    dReqWrite = 1'b0;
    dReqWdata = '0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((iQ.size() + dQ.size() + u1Q.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3;
    checkOutput("queues_drained", 32'(iQ.size() + dQ.size() + u1Q.size()), 32'd0);
  endtask

  // Monitor: pops the matching expectation whenever a response pulse is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (iRespValid || dRespValid)
        checkOutput("resp_overlap", {31'd0, iRespValid & dRespValid}, 32'd0);
      if (iRespValid) begin
        if (iQ.size() == 0) checkOutput("i_resp_unexpected", iRespData, 32'hxxxx_xxxx);
        else begin
          e = iQ.pop_front();
          checkOutput("i_resp_data", iRespData, e.data);
          checkOutput("i_resp_cycle", 32'(cycleCount), 32'(e.cycle));
        end
      end
      if (dRespValid) begin
        if (dQ.size() == 0) checkOutput("d_resp_unexpected", dRespData, 32'hxxxx_xxxx);
        else begin
          e = dQ.pop_front();
          checkOutput("d_resp_data", dRespData, e.data);
          checkOutput("d_resp_cycle", 32'(cycleCount), 32'(e.cycle));
        end
      end
      if (u1DRespValid) begin
        if (u1Q.size() == 0) checkOutput("u1_resp_unexpected", u1DRespData, 32'hxxxx_xxxx);
        else begin
          e = u1Q.pop_front();
          checkOutput("u1_resp_data", u1DRespData, e.data);
          checkOutput("u1_resp_cycle", 32'(cycleCount), 32'(e.cycle));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sCyc, iAcc, dAcc, w0, prevI;
    logic u1Done;
    reset     = 1'b1;
    iReqValid = 1'b1;
    iReqAddr  = '0;
    dReqValid = 1'b1;
    dReqAddr  = '0;
    dReqWrite = 1'b0;
    dReqWdata = '0;
    u1IValid  = 1'b0;
    u1IAddr   = '0;
    u1DValid  = 1'b0;
    u1DAddr   = '0;
    u1DWrite  = 1'b0;
    u1DWdata  = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_i_ready", {31'd0, iReqReady}, 32'd0);
    checkOutput("reset_d_ready", {31'd0, dReqReady}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_mem_we", {31'd0, memWe}, 32'd0);
    checkOutput("reset_mem_addr", memAddr, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    iReqValid = 1'b0;
    dReqValid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    $display("[TB] test 1: single I read");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, sCyc, iAcc, dAcc);
    checkOutput("t1_i_accept_cycle", 32'(iAcc), 32'(sCyc));
    waitIdle();

    $display("[TB] test 2: I and D tie");
    applyStimulus(1'b1, 32'h14, 32'hA000_0005, 1'b1, 32'h18, 1'b0, 32'h0, 32'hA000_0006, 1'b1, sCyc, iAcc, dAcc);
    checkOutput("t2_d_first", 32'(dAcc), 32'(sCyc));
    checkOutput("t2_i_after_d", 32'(iAcc - dAcc), 32'(LAT + 2));
    waitIdle();

    $display("[TB] test 3: D write then I read-back");
    w0 = weCount;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, sCyc, iAcc, dAcc);
    waitIdle();
    checkOutput("t3_we_pulses", 32'(weCount - w0), 32'd1);
    checkOutput("t3_we_addr", weAddr, 32'h20);
    checkOutput("t3_we_data", weData, 32'h1234_5678);
    w0 = weCount;
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, sCyc, iAcc, dAcc);
    waitIdle();
    checkOutput("t3_i_read_no_we", 32'(weCount - w0), 32'd0);

    $display("[TB] test 4: both sides saturated");
    prevI = -1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h40 + 32'(8 * k), 32'hA000_0010 + 32'(2 * k),
                    1'b1, 32'h80 + 32'(4 * k), 1'b0, 32'h0, 32'hA000_0020 + 32'(k),
                    1'b1, sCyc, iAcc, dAcc);
      checkOutput("t4_i_follows_d", 32'(iAcc - dAcc), 32'(LAT + 2));
      if (k > 0) checkOutput("t4_d_follows_i", 32'(dAcc - prevI), 32'(LAT + 2));
      prevI = iAcc;
    end
    waitIdle();

    $display("[TB] test 5: reset during D write");
    w0 = weCount;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h30, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, sCyc, iAcc, dAcc);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t5_busy_in_reset", {31'd0, busy}, 32'd0);
    checkOutput("t5_we_in_reset", {31'd0, memWe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("t5_no_we_after_reset", 32'(weCount - w0), 32'd0);
    checkOutput("t5_busy_after_reset", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 32'h14, 32'hA000_0005, 1'b1, 32'h18, 1'b0, 32'h0, 32'hA000_0006, 1'b1, sCyc, iAcc, dAcc);
    checkOutput("t5_d_first", 32'(dAcc), 32'(sCyc));
    checkOutput("t5_i_after_d", 32'(iAcc - dAcc), 32'(LAT + 2));
    waitIdle();

    $display("[TB] test 6: LATENCY=1 D read");
    u1Done = 1'b0;
    @(negedge clk);
    sCyc     = cycleCount;
    u1DValid = 1'b1;
    u1DAddr  = 32'h44;
    for (int n = 0; n < 10 && !u1Done; n++) begin
      #1;
      if (u1DReady) begin
        u1Done = 1'b1;
        u1Q.push_back('{32'hC0DE_0044, cycleCount + 2});
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("t6_accept_immediate", {31'd0, u1Done}, 32'd1);
    @(posedge clk);
    #1;
    u1DValid = 1'b0;
    u1DAddr  = 32'hFFFF_FFF0;
    waitIdle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
